// File: rtl/complex_sched_pkg.sv
// complex_sched_pkg: shared types and constants for the complex multiplier scheduler
package complex_sched_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  localparam int DEF_LAT = 12;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);
  logic [IDW-1:0] w_idx;
  // Scan from farthest to nearest so the closest request to ptr wins
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    w_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_id     = w_idx;
        any          = 1'b1;
      end
    end
  end
endmodule

// File: rtl/complex_mult_sched.sv
// complex_mult_sched: round-robin sharing of one pipelined complex multiplier,
// with ID tagging through the pipe, ce-based backpressure and flush/drain.
module complex_mult_sched
  import complex_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LAT  = DEF_LAT,
  parameter int IDW  = id_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*64-1:0]       req_a,
  input  logic [NREQ*64-1:0]       req_b,
  output logic [63:0]              mul_a,
  output logic [63:0]              mul_b,
  output logic                     mul_ce,
  input  logic [63:0]              mul_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_data,
  output logic [IDW-1:0]           out_id,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     busy,
  output logic [$clog2(LAT+1)-1:0] inflight
);
  localparam int CW = $clog2(LAT + 1);
  state_t                   r_state, w_state_nxt;
  logic [IDW-1:0]           r_ptr;
  logic [LAT-1:0]           r_vld;
  logic [LAT-1:0][IDW-1:0]  r_id;
  logic [CW-1:0]            r_inflight;
  logic [NREQ-1:0]          w_grant;
  logic [IDW-1:0]           w_gid;
  logic                     w_any, w_run, w_issue, w_pop;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(r_ptr), .grant(w_grant), .grant_id(w_gid), .any(w_any)
  );

  assign out_valid  = r_vld[LAT-1];
  assign out_id     = r_id[LAT-1];
  assign out_data   = mul_result;
  assign mul_ce     = ~(out_valid & ~out_ready);
  assign w_run      = (r_state == RUN);
  assign w_issue    = w_any & mul_ce & w_run;
  assign w_pop      = out_valid & out_ready;
  assign req_ready  = w_grant & {NREQ{mul_ce & w_run}};
  assign mul_a      = w_any ? req_a[64*w_gid +: 64] : 64'h0;
  assign mul_b      = w_any ? req_b[64*w_gid +: 64] : 64'h0;
  assign inflight   = r_inflight;
  assign flush_done = (r_state == DONE);
  assign busy       = (r_inflight != '0) | ~w_run;

  always_comb
    w_state_nxt = (r_state == RUN)   ? (flush ? DRAIN : RUN) :
                  (r_state == DRAIN) ? ((r_inflight == '0) ? DONE : DRAIN) : RUN;

  // Tags move in lockstep with the multiplier, so a stalled head freezes all of them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_id  <= '0;
    end else if (mul_ce) begin
      r_vld <= {r_vld[LAT-2:0], w_issue};
      r_id  <= {r_id[LAT-2:0], w_gid};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_ptr      <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_pop);
      if (w_issue) r_ptr <= IDW'((int'(w_gid) + 1) % NREQ);
    end
  end
endmodule

// File: doc/complex_mult_sched.md
# complex_mult_sched

Round-robin scheduler sharing one pipelined single-precision complex multiplier (multiply stage plus add/subtract stage, common `ce`) among NREQ requesters. It accepts 64-bit operand pairs, each packed as {real[63:32], imag[31:0]}, and issues at most one pair per cycle. It tracks each pair's requester ID through the fixed pipeline latency and returns results with backpressure by gating the multiplier's `ce`. It sits between the solver's vector engines and the complex multiply datapath and also provides a flush/drain control.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8)
- LAT, 12, total multiplier latency in `ce`-high cycles (multiply + add/sub)
- IDW, $clog2(NREQ) (min 1), requester ID width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept
- req_a  in  NREQ*64  operand A, requester i at [64i+63:64i]
- req_b  in  NREQ*64  operand B, same packing
- mul_a, mul_b  out  64  operands to multiplier
- mul_ce  out  1  multiplier clock enable
- mul_result  in  64  multiplier result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_data  out  64  result (= mul_result)
- out_id  out  IDW  originating requester
- flush  in  1  drain request (level; sampled in RUN)
- flush_done  out  1  one-cycle pulse, pipeline empty after flush
- busy  out  1  inflight != 0 or state != RUN
- inflight  out  $clog2(LAT+1)  pairs issued, not yet returned

## Operation
- Tag pipeline: LAT stages of {valid, id}. Advances only when mul_ce=1. Stage 0 loads {issue, grant_id}.
- out_valid = stage[LAT-1].valid; out_id = stage[LAT-1].id.
- mul_ce = ~(out_valid & ~out_ready). A blocked head freezes the whole pipeline.
- Arbitration: round-robin starting from pointer `ptr`. Grant is the first i ≥ ptr (wrapping) with req_valid[i].
- issue = any grant & mul_ce & state==RUN.
- req_ready[i] = grant[i] & mul_ce & state==RUN.
- On issue, ptr ← grant_id+1 mod NREQ. Otherwise ptr holds.
- mul_a/mul_b = granted operands; 0 when nothing is granted.
- inflight: +1 on issue, −1 on out_valid&out_ready. It is unchanged when both occur and never exceeds LAT.
- FSM:
  - RUN: on flush, go to DRAIN.
  - DRAIN: no issue. When inflight==0, go to DONE.
  - DONE: flush_done=1, then go to RUN.
- Flush while already empty: DRAIN lasts one cycle, then DONE.
- req_valid asserted in DRAIN/DONE waits, with no ready, until RUN.

## Timing
- Reset values: req_ready=0, mul_ce=1, mul_a/mul_b=0, out_valid=0, out_id=0, flush_done=0, busy=0, inflight=0, ptr=0, state=RUN.
- Asserting rst_n low mid-operation clears all tags immediately. In-flight results are discarded, not reported.
- Latency: a pair issued at edge t yields out_valid after exactly LAT more `ce`-high edges. With no stalls, the result is visible in cycle t+LAT.
- Throughput: 1 pair/cycle. No bubbles are inserted by the scheduler.
- A stall cycle holds every tag and req_ready=0 for all requesters.
- flush_done rises the cycle after inflight reaches 0 in DRAIN.

## Structure
- Package complex_sched_pkg holds:
  - state enum {RUN, DRAIN, DONE}
  - default LAT constant
  - helper function for IDW
- Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot grant, grant_id, any. Purely combinational.
- Top level contains the tag shift register, inflight counter, FSM and ce logic.

## Test plan
- Single request: requester 0 sends A=0x3F80000040000000 (1+2j), B=0x4040000040800000 (3+4j), out_ready=1.
  - Response: out_valid exactly 12 cycles later with out_data=0xC0A0000041200000 (−5+10j) and out_id=0.
- Contention: both requesters valid continuously for 8 cycles from reset.
  - Response: grants alternate 0,1,0,1… and out_id follows the same order.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1.
  - Response: mul_ce=0 and req_ready=0 for those 5 cycles, out_data/out_id stable, no result lost or duplicated.
- Flush: pulse flush with 3 pairs in flight.
  - Response: no req_ready during drain, 3 results returned, then a flush_done pulse once inflight=0, then RUN resumes.
- Flush while idle.
  - Response: flush_done 2 cycles after flush, busy high for those 2 cycles only.
- Reset mid-stream: rst_n low with 6 pairs in flight.
  - Response: out_valid=0 and inflight=0 immediately; the first post-reset issue is granted to requester 0.
